// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        REFILL_REQ,
        REFILL_WAIT,
        WT_REQ,
        RESPOND
    } state_t;

    // Way index width; a direct-mapped cache still carries a 1-bit way index.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_way_select.sv
// Per-way tag compare for one set: hit detection (lowest way wins) and victim choice
// (lowest invalid way, otherwise the set's round-robin pointer).
module cache_way_select
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int TAG_W = 28
) (
    input  logic [WAYS*TAG_W-1:0]     tags_i,
    input  logic [WAYS-1:0]           valid_i,
    input  logic [TAG_W-1:0]          tag_i,
    input  logic [way_bits(WAYS)-1:0] rr_ptr_i,
    output logic                      hit_o,
    output logic [way_bits(WAYS)-1:0] hit_way_o,
    output logic [way_bits(WAYS)-1:0] victim_o,
    output logic                      use_rr_o
);

    localparam int WAY_W = way_bits(WAYS);

    // Scanning from the top way down lets the lowest matching/invalid way overwrite the rest.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        hit_o     = 1'b0;
        hit_way_o = '0;
        victim_o  = rr_ptr_i;
        use_rr_o  = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_i[w] && (tags_i[w*TAG_W +: TAG_W] == tag_i)) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_W'(w);
            end
            if (!valid_i[w]) begin
                victim_o = WAY_W'(w);
                use_rr_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative cache controller with internal tag/valid/dirty/data arrays,
// refill FSM, write-back or write-through policy, round-robin replacement and hit/miss counters.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter bit WRITE_BACK = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = way_bits(WAYS);

    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [WAY_W-1:0]  victim_q;
    logic              rsp_hit_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic [IDX_W-1:0]      set_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WAYS*TAG_W-1:0] set_tags;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic                  use_rr;
    logic                  evict;
    logic                  rr_adv;
    logic [WAY_W-1:0]      rr_next;

    logic              arr_we;
    logic [WAY_W-1:0]  arr_way;
    logic [DATA_W-1:0] arr_data;
    logic              arr_dirty;

    assign set_idx = req_addr_q[IDX_W-1:0];
    assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

    always_comb begin
        set_tags = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_tags[w*TAG_W +: TAG_W] = tag_q[set_idx][w];
        end
    end

    cache_way_select #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_way_select (
        .tags_i    (set_tags),
        .valid_i   (valid_q[set_idx]),
        .tag_i     (req_tag),
        .rr_ptr_i  (rr_q[set_idx]),
        .hit_o     (hit),
        .hit_way_o (hit_way),
        .victim_o  (victim),
        .use_rr_o  (use_rr)
    );

    // A dirty victim only exists in write-back mode; write-through never sets dirty.
    assign evict   = !hit && WRITE_BACK && valid_q[set_idx][victim] && dirty_q[set_idx][victim];
    assign rr_adv  = !hit && use_rr && (WRITE_BACK || !req_we_q);
    assign rr_next = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + WAY_W'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (req_valid) state_d = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    state_d = (req_we_q && !WRITE_BACK) ? WT_REQ : RESPOND;
                end else if (WRITE_BACK) begin
                    if (evict)         state_d = WB_REQ;
                    else if (req_we_q) state_d = RESPOND;
                    else               state_d = REFILL_REQ;
                end else begin
                    state_d = req_we_q ? WT_REQ : REFILL_REQ;
                end
            end
            WB_REQ:      if (mem_req_ready) state_d = req_we_q ? RESPOND : REFILL_REQ;
            REFILL_REQ:  if (mem_req_ready) state_d = REFILL_WAIT;
            REFILL_WAIT: if (mem_rsp_valid) state_d = RESPOND;
            WT_REQ:      if (mem_req_ready) state_d = RESPOND;
            RESPOND:     state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Single array write port: write hits, write-allocate installs and refill installs.
    always_comb begin
        arr_we    = 1'b0;
        arr_way   = victim_q;
        arr_data  = req_wdata_q;
        arr_dirty = 1'b0;
        unique case (state_q)
            LOOKUP: begin
                if (hit && req_we_q) begin
                    arr_we    = 1'b1;
                    arr_way   = hit_way;
                    arr_dirty = WRITE_BACK;
                end else if (!hit && WRITE_BACK && req_we_q && !evict) begin
                    arr_we    = 1'b1;
                    arr_way   = victim;
                    arr_dirty = 1'b1;
                end
            end
            WB_REQ: begin
                if (mem_req_ready && req_we_q) begin
                    arr_we    = 1'b1;
                    arr_dirty = 1'b1;
                end
            end
            REFILL_WAIT: begin
                if (mem_rsp_valid) begin
                    arr_we   = 1'b1;
                    arr_data = mem_rsp_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: tag/data arrays carry no reset; valid_q qualifies every entry so their contents never matter after reset.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_q[set_idx][arr_way]  <= req_tag;
            data_q[set_idx][arr_way] <= arr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                req_we_q    <= req_we;
                req_addr_q  <= req_addr;
                req_wdata_q <= req_wdata;
            end
            if (arr_we) begin
                valid_q[set_idx][arr_way] <= 1'b1;
                dirty_q[set_idx][arr_way] <= arr_dirty;
            end
            unique case (state_q)
                LOOKUP: begin
                    victim_q    <= victim;
                    rsp_hit_q   <= hit;
                    rsp_rdata_q <= req_we_q ? req_wdata_q : data_q[set_idx][hit_way];
                    if (evict) begin
                        mem_addr_q  <= {tag_q[set_idx][victim], set_idx};
                        mem_wdata_q <= data_q[set_idx][victim];
                    end else begin
                        mem_addr_q  <= req_addr_q;
                        mem_wdata_q <= req_wdata_q;
                    end
                    if (hit) begin
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    end
                    if (rr_adv) rr_q[set_idx] <= rr_next;
                end
                WB_REQ:      if (mem_req_ready) mem_addr_q <= req_addr_q;
                REFILL_WAIT: if (mem_rsp_valid) rsp_rdata_q <= mem_rsp_rdata;
                default: ;
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESPOND);
    assign rsp_hit       = rsp_hit_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign mem_req_valid = (state_q == WB_REQ) || (state_q == REFILL_REQ) || (state_q == WT_REQ);
    assign mem_req_we    = (state_q == WB_REQ) || (state_q == WT_REQ);
    assign mem_req_addr  = mem_addr_q;
    assign mem_req_wdata = mem_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench: a write-back and a write-through instance share stimulus; `sel` picks the one checked.
module tb_set_assoc_cache_ctrl;

    typedef struct {
        logic       hit;
        logic [7:0] rdata;
        int         acc;
        bit         chk_lat;
    } exp_rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } exp_mem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        mem_req_ready, mem_rsp_valid;
    logic [7:0]  mem_rsp_rdata;

    logic        wb_req_ready, wb_rsp_valid, wb_rsp_hit, wb_mem_req_valid, wb_mem_req_we;
    logic [7:0]  wb_rsp_rdata, wb_mem_req_wdata;
    logic [31:0] wb_mem_req_addr;
    logic [15:0] wb_hit_count, wb_miss_count;
    logic        wt_req_ready, wt_rsp_valid, wt_rsp_hit, wt_mem_req_valid, wt_mem_req_we;
    logic [7:0]  wt_rsp_rdata, wt_mem_req_wdata;
    logic [31:0] wt_mem_req_addr;
    logic [15:0] wt_hit_count, wt_miss_count;

    logic        sel = 1'b0;
    logic        cur_req_ready, cur_rsp_valid, cur_rsp_hit, cur_mem_req_valid, cur_mem_req_we;
    logic [7:0]  cur_rsp_rdata, cur_mem_req_wdata;
    logic [31:0] cur_mem_req_addr;
    logic [15:0] cur_hit_count, cur_miss_count;

    assign cur_req_ready     = sel ? wt_req_ready     : wb_req_ready;
    assign cur_rsp_valid     = sel ? wt_rsp_valid     : wb_rsp_valid;
    assign cur_rsp_hit       = sel ? wt_rsp_hit       : wb_rsp_hit;
    assign cur_rsp_rdata     = sel ? wt_rsp_rdata     : wb_rsp_rdata;
    assign cur_mem_req_valid = sel ? wt_mem_req_valid : wb_mem_req_valid;
    assign cur_mem_req_we    = sel ? wt_mem_req_we    : wb_mem_req_we;
    assign cur_mem_req_addr  = sel ? wt_mem_req_addr  : wb_mem_req_addr;
    assign cur_mem_req_wdata = sel ? wt_mem_req_wdata : wb_mem_req_wdata;
    assign cur_hit_count     = sel ? wt_hit_count     : wb_hit_count;
    assign cur_miss_count    = sel ? wt_miss_count    : wb_miss_count;

    set_assoc_cache_ctrl #(.WRITE_BACK(1'b1)) dut_wb (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(wb_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(wb_rsp_valid), .rsp_hit(wb_rsp_hit), .rsp_rdata(wb_rsp_rdata),
        .mem_req_valid(wb_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(wb_mem_req_we),
        .mem_req_addr(wb_mem_req_addr), .mem_req_wdata(wb_mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .hit_count(wb_hit_count), .miss_count(wb_miss_count)
    );

    set_assoc_cache_ctrl #(.WRITE_BACK(1'b0)) dut_wt (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(wt_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(wt_rsp_valid), .rsp_hit(wt_rsp_hit), .rsp_rdata(wt_rsp_rdata),
        .mem_req_valid(wt_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(wt_mem_req_we),
        .mem_req_addr(wt_mem_req_addr), .mem_req_wdata(wt_mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .hit_count(wt_hit_count), .miss_count(wt_miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_rsp_t   exp_rsp_q[$];
    exp_mem_t   exp_mem_q[$];
    logic [7:0] refill_q[$];
    int         stall_left = 0;
    int         stall_obs  = 0;
    int         resp_lat   = 2;
    int         rsp_delay  = 0;
    logic [7:0] pending    = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [7:0] wdata);
        exp_mem_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        exp_mem_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] wdata,
                         input logic exp_hit, input logic [7:0] exp_rdata, input bit chk_lat);
        exp_rsp_t e;
        int n = 0;
        @(negedge clk);
        while (!cur_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cur_req_ready) begin
            check("req_ready_timeout", cur_req_ready, 1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        e.hit = exp_hit; e.rdata = exp_rdata; e.acc = cyc + 1; e.chk_lat = chk_lat;
        exp_rsp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_rsp_q.size() != 0 || exp_mem_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_rsp", exp_rsp_q.size(), 0);
        check("drain_mem", exp_mem_q.size(), 0);
        exp_rsp_q.delete();
        exp_mem_q.delete();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall_left = 0;
        rsp_delay  = 0;
        refill_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: pops one expectation per rsp_valid cycle.
    initial begin
        exp_rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cur_rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", cur_rsp_valid, 0);
                end else begin
                    e = exp_rsp_q.pop_front();
                    check("rsp_hit", cur_rsp_hit, e.hit);
                    check("rsp_rdata", cur_rsp_rdata, e.rdata);
                    // Accept at edge N: response must already be visible before edge N+2.
                    if (e.chk_lat) check("rsp_latency", cyc - e.acc, 1);
                end
            end
        end
    end

    // Memory model: drives ready/stalls, checks each handshake, returns refill data after resp_lat cycles.
    initial begin
        exp_mem_t e;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (rsp_delay > 0) begin
                rsp_delay--;
                if (rsp_delay == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = pending;
                end
            end
            if (stall_left > 0) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (cur_mem_req_valid && !mem_req_ready && exp_mem_q.size() != 0) begin
                stall_obs++;
                check("stall_we", cur_mem_req_we, exp_mem_q[0].we);
                check("stall_addr", cur_mem_req_addr, exp_mem_q[0].addr);
                check("stall_req_ready", cur_req_ready, 0);
                check("stall_rsp_valid", cur_rsp_valid, 0);
            end
            if (cur_mem_req_valid && mem_req_ready) begin
                if (exp_mem_q.size() == 0) begin
                    check("mem_unexpected", cur_mem_req_valid, 0);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_we", cur_mem_req_we, e.we);
                    check("mem_addr", cur_mem_req_addr, e.addr);
                    if (e.we) check("mem_wdata", cur_mem_req_wdata, e.wdata);
                end
                if (!cur_mem_req_we) begin
                    pending   = (refill_q.size() != 0) ? refill_q.pop_front() : 8'h00;
                    rsp_delay = resp_lat;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        do_reset();

        check("rst_req_ready", cur_req_ready, 1);
        check("rst_rsp_valid", cur_rsp_valid, 0);
        check("rst_rsp_hit", cur_rsp_hit, 0);
        check("rst_rsp_rdata", cur_rsp_rdata, 0);
        check("rst_mem_valid", cur_mem_req_valid, 0);
        check("rst_mem_we", cur_mem_req_we, 0);
        check("rst_mem_addr", cur_mem_req_addr, 0);
        check("rst_mem_wdata", cur_mem_req_wdata, 0);
        check("rst_hit_count", cur_hit_count, 0);
        check("rst_miss_count", cur_miss_count, 0);

        // Read miss with refill, then hit with fixed latency.
        refill_q.push_back(8'hAA);
        push_mem(1'b0, 32'h10, 8'h00);
        issue(1'b0, 32'h10, 8'h00, 1'b0, 8'hAA, 1'b0);
        wait_done();
        check("t1_miss_count", cur_miss_count, 1);
        check("t1_hit_count0", cur_hit_count, 0);
        issue(1'b0, 32'h10, 8'h00, 1'b1, 8'hAA, 1'b1);
        wait_done();
        check("t1_hit_count", cur_hit_count, 1);

        // Write-allocate without memory traffic.
        do_reset();
        issue(1'b1, 32'h20, 8'hCC, 1'b0, 8'hCC, 1'b0);
        issue(1'b0, 32'h20, 8'h00, 1'b1, 8'hCC, 1'b1);
        wait_done();

        // Dirty eviction of way 0, then refill; the other way keeps its line.
        do_reset();
        issue(1'b1, 32'h30, 8'h11, 1'b0, 8'h11, 1'b0);
        issue(1'b1, 32'h130, 8'h22, 1'b0, 8'h22, 1'b0);
        push_mem(1'b1, 32'h30, 8'h11);
        push_mem(1'b0, 32'h230, 8'h00);
        refill_q.push_back(8'h5A);
        issue(1'b0, 32'h230, 8'h00, 1'b0, 8'h5A, 1'b0);
        issue(1'b0, 32'h130, 8'h00, 1'b1, 8'h22, 1'b0);
        wait_done();
        check("t3_miss_count", cur_miss_count, 3);
        check("t3_hit_count", cur_hit_count, 1);

        // Memory back-pressure during a refill request.
        do_reset();
        stall_obs = 0;
        refill_q.push_back(8'h3C);
        push_mem(1'b0, 32'h40, 8'h00);
        stall_left = 9;
        issue(1'b0, 32'h40, 8'h00, 1'b0, 8'h3C, 1'b0);
        wait_done();
        check("t4_stall_cycles", (stall_obs >= 5) ? 32'd1 : 32'd0, 1);

        // Write-through: write hit updates memory and cache; write miss does not allocate.
        sel = 1'b1;
        do_reset();
        refill_q.push_back(8'h33);
        push_mem(1'b0, 32'h10, 8'h00);
        issue(1'b0, 32'h10, 8'h00, 1'b0, 8'h33, 1'b0);
        push_mem(1'b1, 32'h10, 8'h55);
        issue(1'b1, 32'h10, 8'h55, 1'b1, 8'h55, 1'b0);
        issue(1'b0, 32'h10, 8'h00, 1'b1, 8'h55, 1'b1);
        push_mem(1'b1, 32'h40, 8'h77);
        issue(1'b1, 32'h40, 8'h77, 1'b0, 8'h77, 1'b0);
        refill_q.push_back(8'h44);
        push_mem(1'b0, 32'h40, 8'h00);
        issue(1'b0, 32'h40, 8'h00, 1'b0, 8'h44, 1'b0);
        wait_done();
        check("t5_hit_count", cur_hit_count, 2);
        check("t5_miss_count", cur_miss_count, 3);

        // Reset while waiting for refill data; the late data must be ignored.
        sel = 1'b0;
        do_reset();
        resp_lat = 6;
        refill_q.push_back(8'h99);
        push_mem(1'b0, 32'h10, 8'h00);
        issue(1'b0, 32'h10, 8'h00, 1'b0, 8'h99, 1'b0);
        n = 0;
        while (exp_mem_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_refill_issued", exp_mem_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_req_ready", cur_req_ready, 1);
        check("t6_rsp_valid", cur_rsp_valid, 0);
        check("t6_mem_valid", cur_mem_req_valid, 0);
        check("t6_mem_addr", cur_mem_req_addr, 0);
        check("t6_miss_count", cur_miss_count, 0);
        exp_rsp_q.delete();
        exp_mem_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        resp_lat = 2;
        refill_q.push_back(8'h66);
        push_mem(1'b0, 32'h10, 8'h00);
        issue(1'b0, 32'h10, 8'h00, 1'b0, 8'h66, 1'b0);
        wait_done();
        check("t6_post_miss", cur_miss_count, 1);
        check("t6_post_hit", cur_hit_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
